// File: rtl/leaf_vote_collector.sv
// rtl/leaf_vote_collector.sv - maps per-tree leaf indices to classes, tallies votes, emits majority class
module leaf_vote_collector #(
  parameter int NUM_TREES = 3,
  parameter int IDX_W     = 4,
  parameter int CLASS_W   = 2,
  parameter int TREE_W    = 2,
  parameter int CNT_W     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_TREES*IDX_W-1:0] leafIdx,
  input  logic [NUM_TREES-1:0]       leafVal,
  output logic [NUM_TREES-1:0]       leafRec,
  input  logic                       tblWe,
  input  logic [TREE_W-1:0]          tblTree,
  input  logic [IDX_W-1:0]           tblIdx,
  input  logic [CLASS_W-1:0]         tblClass,
  output logic [CLASS_W-1:0]         classOut,
  output logic [CNT_W-1:0]           voteCnt,
  output logic                       classVal,
  input  logic                       classRec,
  output logic [15:0]                sampleCnt
);

  localparam int NUM_CLASSES = 2 ** CLASS_W;
  localparam int NUM_LEAVES  = 2 ** IDX_W;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_TALLY   = 2'd1,
    ST_DECIDE  = 2'd2,
    ST_OUT     = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [NUM_TREES-1:0] got;
  logic [IDX_W-1:0]     cap   [NUM_TREES];
  logic [CLASS_W-1:0]   tbl   [NUM_TREES][NUM_LEAVES];
  logic [CNT_W-1:0]     votes [NUM_CLASSES];
  logic [TREE_W-1:0]    t;

  logic [NUM_TREES-1:0] accept;
  logic                 all_in;
  logic                 last_tree;
  logic                 xfer;
  logic [CLASS_W-1:0]   tally_class;
  logic [CLASS_W-1:0]   best_class;
  logic [CNT_W-1:0]     best_cnt;

  assign accept      = leafVal & leafRec;
  // A sample is complete once every tree has either been captured earlier or is captured now
  assign all_in      = &(got | accept);
  assign last_tree   = (32'(t) == NUM_TREES - 1);
  assign xfer        = (state == ST_OUT) && classVal && classRec;
  // Combinational table read; a same-edge write lands after this read is consumed
  assign tally_class = tbl[t][cap[t]];

  // Argmax over vote counters; strict compare keeps the lowest class on ties
  always_comb begin
    best_class = '0;
    best_cnt   = votes[0];
    for (int c = 1; c < NUM_CLASSES; c++) begin
      if (votes[c] > best_cnt) begin
        best_class = CLASS_W'(c);
        best_cnt   = votes[c];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_COLLECT;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_COLLECT: if (all_in) state_nxt = ST_TALLY;
      ST_TALLY:   if (last_tree) state_nxt = ST_DECIDE;
      ST_DECIDE:  state_nxt = ST_OUT;
      ST_OUT:     if (xfer) state_nxt = ST_COLLECT;
      default:    state_nxt = ST_COLLECT;
    endcase
  end

  // Per-tree ready: only while collecting and only for trees not yet captured
  always_comb begin
    leafRec = '0;
    if (rst && (state == ST_COLLECT)) leafRec = ~got;
  end

  // Leaf capture, vote accumulation, decision and output handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      got       <= '0;
      t         <= '0;
      classOut  <= '0;
      voteCnt   <= '0;
      classVal  <= 1'b0;
      sampleCnt <= '0;
      for (int i = 0; i < NUM_TREES; i++) cap[i] <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) votes[c] <= '0;
    end else begin
      case (state)
        ST_COLLECT: begin
          for (int i = 0; i < NUM_TREES; i++) begin
            if (accept[i]) begin
              cap[i] <= leafIdx[i*IDX_W +: IDX_W];
              got[i] <= 1'b1;
            end
          end
          if (all_in) t <= '0;
        end
        ST_TALLY: begin
          if (votes[tally_class] != '1)
            votes[tally_class] <= votes[tally_class] + CNT_W'(1);
          t <= last_tree ? '0 : t + TREE_W'(1);
        end
        ST_DECIDE: begin
          classOut <= best_class;
          voteCnt  <= best_cnt;
          classVal <= 1'b1;
        end
        ST_OUT: begin
          if (xfer) begin
            classVal  <= 1'b0;
            got       <= '0;
            sampleCnt <= sampleCnt + 16'd1;
            for (int c = 0; c < NUM_CLASSES; c++) votes[c] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Leaf-to-class table; writes to a nonexistent tree are dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_TREES; i++)
        for (int l = 0; l < NUM_LEAVES; l++)
          tbl[i][l] <= '0;
    end else if (tblWe && (32'(tblTree) < NUM_TREES)) begin
      tbl[tblTree][tblIdx] <= tblClass;
    end
  end

endmodule

// File: tb/tb_leaf_vote_collector.sv
// tb/tb_leaf_vote_collector.sv - directed scoreboard bench for leaf_vote_collector
module tb_leaf_vote_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] leafIdx;
  logic [2:0]  leafVal;
  logic [2:0]  leafRec;
  logic        tblWe;
  logic [1:0]  tblTree;
  logic [3:0]  tblIdx;
  logic [1:0]  tblClass;
  logic [1:0]  classOut;
  logic [1:0]  voteCnt;
  logic        classVal;
  logic        classRec;
  logic [15:0] sampleCnt;

  int tests = 0;
  int fails = 0;
  int samples = 0;
  logic [3:0] sb [$];

  leaf_vote_collector dut (
    .clk(clk), .rst(rst),
    .leafIdx(leafIdx), .leafVal(leafVal), .leafRec(leafRec),
    .tblWe(tblWe), .tblTree(tblTree), .tblIdx(tblIdx), .tblClass(tblClass),
    .classOut(classOut), .voteCnt(voteCnt), .classVal(classVal), .classRec(classRec),
    .sampleCnt(sampleCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_tbl(input logic [1:0] tr, input logic [3:0] idx, input logic [1:0] cls);
    tblWe = 1'b1; tblTree = tr; tblIdx = idx; tblClass = cls;
    tick();
    tblWe = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    logic [3:0] e;
    while (classVal !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, classVal, 1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, sb.size(), 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_class"}, classOut, e[3:2]);
      check({tag, "_votes"}, voteCnt, e[1:0]);
    end
    classRec = 1'b1;
    tick();
    classRec = 1'b0;
    samples++;
    check({tag, "_samplecnt"}, sampleCnt, samples);
    check({tag, "_valid_low"}, classVal, 0);
  endtask

  initial begin
    rst = 1'b0; leafIdx = '0; leafVal = '0; tblWe = 1'b0; tblTree = '0;
    tblIdx = '0; tblClass = '0; classRec = 1'b0;
    tick(); tick();
    check("rst_leafrec", leafRec, 3'b000);
    check("rst_classval", classVal, 0);
    check("rst_classout", classOut, 0);
    check("rst_votecnt", voteCnt, 0);
    check("rst_samplecnt", sampleCnt, 0);
    rst = 1'b1;
    #1 check("rel_leafrec", leafRec, 3'b111);
    tick();

    // Basic sample with exact latency
    write_tbl(2'd0, 4'd3, 2'd1);
    write_tbl(2'd1, 4'd4, 2'd1);
    write_tbl(2'd2, 4'd5, 2'd2);
    leafIdx = {4'd5, 4'd4, 4'd3}; leafVal = 3'b111;
    sb.push_back({2'd1, 2'd2});
    tick();
    leafVal = 3'b000;
    check("basic_rec_drop", leafRec, 3'b000);
    repeat (3) tick();
    check("basic_lat_early", classVal, 0);
    tick();
    check("basic_lat", classVal, 1);
    drain("basic");
    check("basic_rec_back", leafRec, 3'b111);

    // Staggered arrival; tree1 keeps asserting with another index that must be ignored
    leafIdx = {4'd5, 4'd4, 4'd3}; leafVal = 3'b010;
    sb.push_back({2'd1, 2'd2});
    tick();
    leafIdx = {4'd5, 4'd0, 4'd3};
    check("stag_rec1", leafRec, 3'b101);
    tick(); tick();
    leafVal = 3'b011;
    tick();
    check("stag_rec0", leafRec, 3'b100);
    tick(); tick(); tick();
    leafVal = 3'b111;
    tick();
    leafVal = 3'b000;
    check("stag_rec2", leafRec, 3'b000);
    repeat (3) tick();
    check("stag_lat_early", classVal, 0);
    tick();
    check("stag_lat", classVal, 1);
    drain("stag");

    // Three-way tie resolves to lowest class
    write_tbl(2'd0, 4'd3, 2'd2);
    write_tbl(2'd1, 4'd4, 2'd0);
    write_tbl(2'd2, 4'd5, 2'd1);
    leafIdx = {4'd5, 4'd4, 4'd3}; leafVal = 3'b111;
    sb.push_back({2'd0, 2'd1});
    tick(); leafVal = 3'b000;
    drain("tie");

    // Unanimous vote reaches the top count
    write_tbl(2'd0, 4'd3, 2'd3);
    write_tbl(2'd1, 4'd4, 2'd3);
    write_tbl(2'd2, 4'd5, 2'd3);
    write_tbl(2'd3, 4'd3, 2'd0);
    leafVal = 3'b111;
    sb.push_back({2'd3, 2'd3});
    tick(); leafVal = 3'b000;
    drain("unan");

    // Backpressure with leaves continuously offered
    write_tbl(2'd0, 4'd3, 2'd1);
    write_tbl(2'd1, 4'd4, 2'd1);
    write_tbl(2'd2, 4'd5, 2'd2);
    leafVal = 3'b111;
    sb.push_back({2'd1, 2'd2});
    begin
      int n = 0;
      while (classVal !== 1'b1 && n < 50) begin tick(); n++; end
    end
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", classVal, 1);
      check("bp_class", classOut, 1);
      check("bp_votes", voteCnt, 2);
      check("bp_rec", leafRec, 3'b000);
      check("bp_samplecnt", sampleCnt, samples);
      tick();
    end
    sb.push_back({2'd1, 2'd2});
    drain("bp_first");
    drain("bp_next");
    leafVal = 3'b000;

    // Table write on the same edge tree1 is tallied uses the old entry
    leafVal = 3'b111;
    sb.push_back({2'd1, 2'd2});
    tick(); leafVal = 3'b000;
    tick();
    tblWe = 1'b1; tblTree = 2'd1; tblIdx = 4'd4; tblClass = 2'd3;
    tick();
    tblWe = 1'b0;
    drain("wr_race");
    leafVal = 3'b111;
    sb.push_back({2'd1, 2'd1});
    tick(); leafVal = 3'b000;
    drain("wr_after");

    // Asynchronous reset during tally
    leafVal = 3'b111;
    tick(); leafVal = 3'b000;
    tick();
    rst = 1'b0;
    #1;
    check("arst_valid", classVal, 0);
    check("arst_rec", leafRec, 3'b000);
    check("arst_samplecnt", sampleCnt, 0);
    samples = 0;
    tick();
    rst = 1'b1;
    #1 check("arst_rec_back", leafRec, 3'b111);
    tick();
    leafVal = 3'b111;
    sb.push_back({2'd0, 2'd3});
    tick(); leafVal = 3'b000;
    drain("arst_cleared");
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/leaf_vote_collector.md
Name: leaf_vote_collector

Overview:
- Sink end of the fixed-point tree-evaluation array; counterpart to sample_feeder at the input end.
- Accepts one leaf node index per tree column from the bottom row of internal_branch_stage_fixed, using that row's nodeIdxOut / nValOut / rec handshake.
- Maps each leaf to a class label through a writable per-tree leaf table, tallies votes and emits one majority class per sample to a downstream consumer.

Parameters:
NUM_TREES, 3, number of tree columns (leaf streams).
IDX_W, 4, leaf node index width (matches branch stage index width).
CLASS_W, 2, class label width; number of classes = 2**CLASS_W.
TREE_W, 2, width of table tree-select field (>= clog2(NUM_TREES)).
CNT_W, 2, vote count width (>= clog2(NUM_TREES+1)).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
leafIdx  in  NUM_TREES*IDX_W  leaf index per tree; tree i at bits [i*IDX_W +: IDX_W].
leafVal  in  NUM_TREES  leaf index valid per tree.
leafRec  out  NUM_TREES  receive (ready) per tree, back to branch stage.
tblWe  in  1  leaf table write enable.
tblTree  in  TREE_W  table write tree select.
tblIdx  in  IDX_W  table write leaf index.
tblClass  in  CLASS_W  table write class label.
classOut  out  CLASS_W  majority class of current sample.
voteCnt  out  CNT_W  votes received by classOut.
classVal  out  1  classOut/voteCnt valid.
classRec  in  1  downstream receive (ready).
sampleCnt  out  16  samples delivered since reset; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (rst=0, async): state=COLLECT, got=0, all votes=0, all table entries=0, classOut=0, voteCnt=0, classVal=0, sampleCnt=0. leafRec=0 while rst=0. Reset mid-operation discards the partial sample and the table contents.
- States: COLLECT, TALLY, DECIDE, OUT.
- leafRec[i] = rst & (state==COLLECT) & ~got[i] (combinational).
- COLLECT:
  - On an edge with leafVal[i]&leafRec[i]: capture leafIdx slice i into cap[i] and set got[i]. Trees are captured independently, in any order or simultaneously.
  - leafVal on a tree already captured is ignored (its leafRec=0).
  - If (got | accepted) == all ones at an edge: go to TALLY with tree counter t=0 on the same edge.
- TALLY: one tree per cycle.
  - Each edge: votes[table[t][cap[t]]] += 1, t += 1.
  - After tree NUM_TREES-1, go to DECIDE.
  - Table reads are combinational; a same-edge tblWe to the entry being read does not affect this vote (old value used).
- DECIDE: one cycle.
  - Register classOut = argmax(votes), voteCnt = max; ties go to the lowest class index.
  - classVal <= 1; go to OUT.
- OUT:
  - classOut, voteCnt and classVal are held stable while classRec=0.
  - On an edge with classVal&classRec: classVal <= 0, got <= 0, votes <= 0, sampleCnt += 1, go to COLLECT.
  - leafRec returns high the cycle after the transfer.
- Latency: classVal rises NUM_TREES+1 edges after the edge that accepts the last leaf (4 for defaults). Minimum sample period is NUM_TREES+3 cycles with classRec tied 1.
- Table: NUM_TREES x 2**IDX_W entries of CLASS_W bits. Writes on any edge with tblWe=1, in any state. tblTree >= NUM_TREES: write ignored.
- Vote counters saturate at 2**CNT_W-1. This cannot occur with legal parameters.

Test Plan:
- Program t0[3]=1, t1[4]=1, t2[5]=2; then present leafIdx={5,4,3} with leafVal=3'b111 for one cycle -> leafRec drops to 000 the next cycle. 4 edges later: classVal=1, classOut=1, voteCnt=2. classRec=1 -> sampleCnt=1, leafRec=111.
- Staggered arrival: tree1 at cycle 0, tree0 at cycle 3, tree2 at cycle 7 with the same table -> each leafRec[i] drops the cycle after its own capture; classVal rises 4 edges after cycle 7 with classOut=1, voteCnt=2.
- Tie: table maps the leaves to classes 2, 0, 1 -> classOut=0, voteCnt=1. Unanimous class 3 -> classOut=3, voteCnt=3.
- Backpressure: classRec=0 for 10 cycles while classVal=1 and all leafVal=1 -> outputs constant, leafRec=000, sampleCnt unchanged. classRec=1 -> one transfer, then the next sample is collected.
- tblWe to t1[4]=3 on the same edge tree1 is tallied -> the vote uses the old class 1. The next sample with the same leaves gives class 1 (t0) vs 3 (t1) vs 2 (t2): a tie, so classOut=1.
- Drop rst to 0 during TALLY -> classVal=0, leafRec=000 immediately, sampleCnt=0, table cleared. After release, leafRec=111 and all leaves map to class 0 -> classOut=0, voteCnt=3.
